// File: rtl/inst_mem_ctrl_if.sv
// Bus bundle for inst_mem_ctrl: fetch port, load port, status and FSM debug.
// Handshake: a fetch is taken on an edge where fetch_req=1 and fetch_ready=1;
// its response is the single fetch_valid cycle after that edge, in order.
interface inst_mem_ctrl_if #(
  parameter int W = 32
);
  logic           fetch_req;
  logic [W-1:0]   pc;
  logic           fetch_ready;
  logic           fetch_valid;
  logic [W-1:0]   fetch_data;
  logic           fetch_fault;
  logic           ld_start;
  logic           ld_valid;
  logic [W-1:0]   ld_addr;
  logic [W-1:0]   ld_data;
  logic [W/8-1:0] ld_be;
  logic           ld_done;
  logic           ld_err;
  logic [15:0]    ld_count;
  logic           busy;
  logic [1:0]     state_dbg;

  modport master (
    output fetch_req, pc, ld_start, ld_valid, ld_addr, ld_data, ld_be, ld_done,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault, ld_err, ld_count,
           busy, state_dbg
  );

  modport slave (
    input  fetch_req, pc, ld_start, ld_valid, ld_addr, ld_data, ld_be, ld_done,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault, ld_err, ld_count,
           busy, state_dbg
  );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction memory with power-up clear sweep, byte-enabled load mode and a
// one-cycle registered fetch port; the array has one write and one read port.
module inst_mem_ctrl #(
  parameter int W              = 32,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_ctrl_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = W / 8;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [W-1:0]  mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          ld_err_q, ld_err_d;
  logic [15:0]   ld_count_q, ld_count_d;
  logic          fvalid_q, ffault_q, fzero_q;
  logic [W-1:0]  rdata_q;

  logic [W-1:0]  pc_word, ld_word;
  logic          pc_ok, ld_ok, fetch_acc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic [NB-1:0] mem_wbe;

  assign pc_word   = {2'b00, bus.pc[W-1:2]};
  assign ld_word   = {2'b00, bus.ld_addr[W-1:2]};
  assign pc_ok     = (bus.pc[1:0] == 2'b00) && (pc_word < W'(DEPTH));
  assign ld_ok     = (bus.ld_addr[1:0] == 2'b00) && (ld_word < W'(DEPTH));
  assign fetch_acc = (state_q == ST_RUN) && bus.fetch_req;

  // CLEAR and LOAD share the single write port; they never overlap.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    ld_err_d   = ld_err_q;
    ld_count_d = ld_count_q;
    mem_we     = 1'b0;
    mem_waddr  = ld_word[AW-1:0];
    mem_wdata  = bus.ld_data;
    mem_wbe    = bus.ld_be;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (clr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        else                         clr_d   = clr_q + AW'(1);
      end
      ST_RUN: begin
        if (bus.ld_start) begin
          state_d    = ST_LOAD;
          ld_err_d   = 1'b0;
          ld_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.ld_valid) begin
          if (ld_ok) begin
            mem_we = 1'b1;
            if (ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
          end else begin
            ld_err_d = 1'b1;
          end
        end
        if (bus.ld_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_q      <= '0;
      ld_err_q   <= 1'b0;
      ld_count_q <= '0;
      fvalid_q   <= 1'b0;
      ffault_q   <= 1'b0;
      fzero_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      ld_err_q   <= ld_err_d;
      ld_count_q <= ld_count_d;
      fvalid_q   <= fetch_acc;
      ffault_q   <= fetch_acc && !pc_ok;
      if (fetch_acc) fzero_q <= !pc_ok;
    end
  end

  // Array has no reset; the read register only loads on a good fetch so the
  // returned word holds between responses (fzero_q masks it after a fault).
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (fetch_acc && pc_ok && !rst) rdata_q <= mem[pc_word[AW-1:0]];
  end

  assign bus.fetch_ready = (state_q == ST_RUN);
  assign bus.busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
  assign bus.fetch_valid = fvalid_q;
  assign bus.fetch_fault = ffault_q;
  assign bus.fetch_data  = fzero_q ? '0 : rdata_q;
  assign bus.ld_err      = ld_err_q;
  assign bus.ld_count    = ld_count_q;
  assign bus.state_dbg   = state_q;
endmodule
